// File: rtl/uart_pkg.sv
// Shared constants for the UART receive-side buffer.
// Holds data/depth defaults and drop-counter geometry.
// Optional statistics are enabled with UART_RX_FIFO_STATS_EN.
package uart_pkg;

    localparam int DBIT_DEF       = 8;
    localparam int DEPTH_LOG2_DEF = 4;

    // Dropped-byte counter geometry (used only when statistics are enabled)
    localparam int                    DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

    // Saturating increment of the dropped-byte counter
    function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] val);
        return (val == DROP_CNT_MAX) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the receive FIFO: one write port, one async read port.
// Write takes effect on the next rising edge; read is combinational from rd_addr.
// No flow control here; the parent decides when a write is allowed.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DBIT-1:0]       wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DBIT-1:0]       rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DBIT-1:0] mem [DEPTH];

    // Storage: cleared on reset so the head reads as zero after reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO between UART receiver and command interface; optional drop stats (UART_RX_FIFO_STATS_EN).
// Latency: write visible 1 cycle after i_rx_done; pop advances o_data 1 cycle after i_rd.
// Backpressure: none to the receiver; bytes arriving while full (and not popping) are dropped and flagged.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBIT       = DBIT_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DBIT-1:0]       i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_rd,
    input  logic                  i_clr_overrun,
    output logic [DBIT-1:0]       o_data,
    output logic                  o_valid,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_overrun
`ifdef UART_RX_FIFO_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0] o_drop_count
`endif
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overrun;

    logic full;
    logic empty;
    logic pop;
    logic wr_acc;
    logic drop;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // A pop is only real when data is present; a write into a full FIFO is
    // still accepted if a pop frees the slot in the same cycle.
    assign pop    = i_rd && !empty;
    assign wr_acc = i_rx_done && (!full || pop);
    assign drop   = i_rx_done && full && !pop;

    uart_rx_fifo_mem #(
        .DBIT       (DBIT),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clock   (i_clock),
        .reset   (i_reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (i_rx_data),
        .rd_addr (rd_ptr),
        .rd_data (o_data)
    );

    // Pointers and occupancy; pointers wrap by natural binary rollover
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun flag; a drop in the clear cycle keeps it set
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_STATS_EN
    logic [DROP_CNT_W-1:0] drop_cnt;

    // Saturating dropped-byte counter; a drop in the clear cycle restarts it at one
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= i_clr_overrun ? {{(DROP_CNT_W-1){1'b0}}, 1'b1} : drop_sat_inc(drop_cnt);
        end else if (i_clr_overrun) begin
            drop_cnt <= '0;
        end
    end

    assign o_drop_count = drop_cnt;
`endif

    assign o_valid   = !empty;
    assign o_empty   = empty;
    assign o_full    = full;
    assign o_count   = count;
    assign o_overrun = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized plus directed bench for uart_rx_fifo with a queue-based reference model.
// Stimulus drives one cycle per call shortly after the rising edge; a monitor checks on the falling edge.
// Drop-counter checks are active when UART_RX_FIFO_STATS_EN is defined.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_empty;
    logic       o_full;
    logic [4:0] o_count;
    logic       o_overrun;
`ifdef UART_RX_FIFO_STATS_EN
    logic [7:0] o_drop_count;
`endif

    uart_rx_fifo dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_rx_data     (rx_data),
        .i_rx_done     (rx_done),
        .i_rd          (rd),
        .i_clr_overrun (clr),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_count       (o_count),
        .o_overrun     (o_overrun)
`ifdef UART_RX_FIFO_STATS_EN
        ,
        .o_drop_count  (o_drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a plain queue, plus flag state
    logic [7:0] model_q [$];
    int         m_ovr  = 0;
    int         m_drop = 0;

    // Scoreboard of bytes expected on o_data when a pop is issued
    logic [7:0] exp_q [$];

    // Snapshot of the model state that the DUT should show during the current cycle
    bit         chk_en   = 1'b0;
    bit         mon_pop  = 1'b0;
    int         snap_cnt = 0;
    logic [7:0] snap_head = '0;
    int         snap_ovr = 0;
    int         snap_drop = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the snapshot and pops the scoreboard on reads
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", int'(o_count), snap_cnt);
            chk("valid", int'(o_valid), int'(snap_cnt != 0));
            chk("empty", int'(o_empty), int'(snap_cnt == 0));
            chk("full", int'(o_full), int'(snap_cnt == DEPTH));
            chk("overrun", int'(o_overrun), snap_ovr);
`ifdef UART_RX_FIFO_STATS_EN
            chk("drop_count", int'(o_drop_count), snap_drop);
`endif
            if (o_valid && snap_cnt != 0) begin
                chk("head", int'(o_data), int'(snap_head));
            end
            if (mon_pop) begin
                if (exp_q.size() == 0) begin
                    chk("pop_scoreboard_empty", 1, 0);
                end else begin
                    chk("pop_data", int'(o_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // One clock cycle of stimulus; updates the model to what the next edge should produce
    task automatic cycle(input bit wr, input logic [7:0] d, input bit r, input bit c);
        bit pop_now;
        bit drop_now;
        @(posedge clk);
        #1;
        snap_cnt  = model_q.size();
        snap_head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        snap_ovr  = m_ovr;
        snap_drop = m_drop;
        rx_done = wr;
        rx_data = d;
        rd      = r;
        clr     = c;
        pop_now  = r && (model_q.size() != 0);
        drop_now = wr && (model_q.size() == DEPTH) && !pop_now;
        mon_pop  = pop_now;
        if (pop_now) begin
            exp_q.push_back(model_q[0]);
            void'(model_q.pop_front());
        end
        if (wr && !drop_now) begin
            model_q.push_back(d);
        end
        if (drop_now) m_ovr = 1;
        else if (c)   m_ovr = 0;
        if (drop_now) m_drop = c ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        else if (c)   m_drop = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_empty"}, int'(o_empty), 1);
        chk({tag, "_full"}, int'(o_full), 0);
        chk({tag, "_count"}, int'(o_count), 0);
        chk({tag, "_overrun"}, int'(o_overrun), 0);
        chk({tag, "_data"}, int'(o_data), 0);
`ifdef UART_RX_FIFO_STATS_EN
        chk({tag, "_drop_count"}, int'(o_drop_count), 0);
`endif
    endtask

    initial begin
        // Power-on reset, then idle
        #17;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) cycle(0, 8'h00, 0, 0);

        // Three writes then three pops
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        cycle(1, 8'h33, 0, 0);
        repeat (3) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // Fill, overflow with 0xAA, clear, then write+pop while full, then drain
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
        cycle(1, 8'hAA, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 1);
        cycle(1, 8'h55, 1, 0);
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 8'h00, 1, 0);

        // Continuous write and pop with data = cycle index
        for (int i = 0; i < 40; i++) cycle(1, 8'(i), 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);

        // Drop-counter saturation and drop-beats-clear
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
        for (int i = 0; i < 260; i++) cycle(1, 8'hEE, 0, 0);
        cycle(1, 8'hEF, 0, 1);
        cycle(0, 8'h00, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0);

        // Randomized traffic: write-heavy then read-heavy phases
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 200; i++) begin
                bit w;
                bit r;
                bit c;
                w = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 80 : 30));
                r = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 35 : 80));
                c = ($urandom_range(0, 99) < 5);
                cycle(w, 8'($urandom_range(0, 255)), r, c);
            end
        end

        // Reset mid-drain with five entries held
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 8'h00, 1, 0);
        for (int i = 0; i < 8; i++) cycle(1, 8'(8'h40 + i), 0, 0);
        repeat (3) cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_reset_count", int'(o_count), 5);
        chk_en  = 1'b0;
        mon_pop = 1'b0;
        rd      = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_q.delete();
        exp_q.delete();
        m_ovr  = 0;
        m_drop = 0;
        rx_done = 1'b0;
        rd      = 1'b0;
        clr     = 1'b0;
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        snap_cnt  = 0;
        snap_head = 8'h00;
        snap_ovr  = 0;
        snap_drop = 0;
        chk_en    = 1'b1;
        cycle(1, 8'h7E, 0, 0);
        cycle(0, 8'h00, 0, 0);
        #1;
        chk("after_reset_valid", int'(o_valid), 1);
        chk("after_reset_data", int'(o_data), 8'h7E);
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
